// File: rtl/vrotr32_seq.sv
// Lane-serial per-lane 32-bit rotate-right over a 128-bit state (inverse of the
// AES-unit left rotate). LANES_PER_CYCLE lanes are rotated per BUSY cycle.

module vrotr32_lane (
    input  logic [31:0] x,
    input  logic [4:0]  n,
    output logic [31:0] y
);
    // Rotating the doubled word keeps every shift below 64, so n=0 needs no special case.
    logic [63:0] dbl;
    assign dbl = {x, x} >> n;
    assign y   = dbl[31:0];
endmodule

module vrotr32_seq #(
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] bits_to_rotate,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);
    if (!(LANES_PER_CYCLE == 1 || LANES_PER_CYCLE == 2 || LANES_PER_CYCLE == 4)) begin : g_bad_lpc
        $error("vrotr32_seq: LANES_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP = 2'(LANES_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'(4 - LANES_PER_CYCLE);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} st_t;

    typedef struct packed {
        logic [3:0][31:0] x;
        logic [3:0][4:0]  n;
    } op_t;

    st_t              st;
    logic [1:0]       cnt;
    op_t              op;
    logic [3:0][31:0] res;

    logic [LANES_PER_CYCLE-1:0][1:0]  grp_idx;
    logic [LANES_PER_CYCLE-1:0][31:0] grp_y;

    // Only the low 5 bits of each amount word are meaningful.
    logic unused_amt;
    assign unused_amt = ^bits_to_rotate;

    for (genvar k = 0; k < LANES_PER_CYCLE; k++) begin : g_lane
        assign grp_idx[k] = cnt + 2'(k);
        vrotr32_lane u_lane (
            .x (op.x[grp_idx[k]]),
            .n (op.n[grp_idx[k]]),
            .y (grp_y[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            cnt       <= 2'd0;
            op        <= '0;
            res       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        op.x <= state_in;
                        for (int i = 0; i < 4; i++)
                            op.n[i] <= bits_to_rotate[i*32 +: 5];
                        cnt <= 2'd0;
                        st  <= BUSY;
                    end
                end
                BUSY: begin
                    for (int k = 0; k < LANES_PER_CYCLE; k++)
                        res[grp_idx[k]] <= grp_y[k];
                    cnt <= cnt + STEP;
                    if (cnt == LAST) begin
                        st        <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        st        <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    st        <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (st == IDLE) && !rst;
    assign busy      = (st != IDLE);
    assign state_out = res;
endmodule

// File: tb/tb_vrotr32_seq.sv
// Bench for vrotr32_seq: one instance per legal LANES_PER_CYCLE sharing the stimulus;
// table vectors, hold/reset sequences and a random round-trip through a left-rotate model.

module tb_vrotr32_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, in_valid, out_ready;
    logic [127:0]       state_in, bits_to_rotate;
    logic [2:0]         in_ready, out_valid, busy;
    logic [2:0][127:0]  state_out;

    int total = 0;
    int bad   = 0;
    int lat_exp [3] = '{4, 2, 1};
    int lpc     [3] = '{1, 2, 4};

    vrotr32_seq #(.LANES_PER_CYCLE(1)) u_l1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .state_in(state_in), .bits_to_rotate(bits_to_rotate), .out_valid(out_valid[0]),
        .out_ready(out_ready), .state_out(state_out[0]), .busy(busy[0]));
    vrotr32_seq #(.LANES_PER_CYCLE(2)) u_l2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .state_in(state_in), .bits_to_rotate(bits_to_rotate), .out_valid(out_valid[1]),
        .out_ready(out_ready), .state_out(state_out[1]), .busy(busy[1]));
    vrotr32_seq #(.LANES_PER_CYCLE(4)) u_l4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[2]),
        .state_in(state_in), .bits_to_rotate(bits_to_rotate), .out_valid(out_valid[2]),
        .out_ready(out_ready), .state_out(state_out[2]), .busy(busy[2]));

    typedef struct {
        logic [127:0] x;
        logic [127:0] amt;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        logic [63:0] t;
        t = {32'b0, v} << n;
        return t[31:0] | t[63:32];
    endfunction

    task automatic wait_ready(input string name, output bit ok);
        int w = 0;
        while (in_ready !== 3'b111 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        ok = (in_ready === 3'b111);
        if (!ok) chk({name, " ready timeout"}, 128'(in_ready), 128'h7);
    endtask

    task automatic run_op(input string name, input logic [127:0] x, input logic [127:0] amt,
                          input logic [127:0] exp);
        int           lat  [3];
        logic [127:0] got  [3];
        bit           seen [3];
        bit           ok;
        wait_ready(name, ok);
        if (!ok) return;
        state_in = x; bits_to_rotate = amt; out_ready = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin lat[i] = 0; seen[i] = 0; got[i] = '0; end
        for (int c = 1; c <= 12 && !(seen[0] && seen[1] && seen[2]); c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++)
                if (!seen[i] && out_valid[i]) begin
                    seen[i] = 1; lat[i] = c; got[i] = state_out[i];
                end
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s lpc%0d latency", name, lpc[i]), 128'(lat[i]), 128'(lat_exp[i]));
            chk($sformatf("%s lpc%0d data", name, lpc[i]), got[i], exp);
        end
    endtask

    initial begin
        bit ok;
        tbl[0] = '{128'h33333333_22222222_11111111_00000001,
                   128'h00000000_00000000_00000000_00000001,
                   128'h33333333_22222222_11111111_80000000};
        tbl[1] = '{128'h12345678_DEADBEEF_80000000_0000000F,
                   128'h00000004_00000000_0000001F_00000004,
                   128'h81234567_DEADBEEF_00000001_F0000000};
        tbl[2] = '{128'h00000002_1234ABCD_000000AB_A5A5A5A5,
                   128'h00000021_00000010_00000048_FFFFFFE0,
                   128'h00000001_ABCD1234_AB000000_A5A5A5A5};
        tbl[3] = '{128'h80000001_FFFF0000_00000003_7FFFFFFF,
                   128'h00000001_00000010_00000002_0000001F,
                   128'hC0000000_0000FFFF_C0000000_FFFFFFFE};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state_in = '0; bits_to_rotate = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset out_valid", 128'(out_valid), 128'h0);
        chk("reset in_ready", 128'(in_ready), 128'h0);
        chk("reset busy", 128'(busy), 128'h0);
        for (int i = 0; i < 3; i++) chk($sformatf("reset state_out lpc%0d", lpc[i]), state_out[i], '0);
        rst = 1'b0;
        #1;
        chk("post-reset in_ready", 128'(in_ready), 128'h7);

        for (int t = 0; t < 4; t++)
            run_op($sformatf("vec%0d", t), tbl[t].x, tbl[t].amt, tbl[t].exp);

        // Back-pressure in DONE: result held, new offers dropped.
        wait_ready("hold", ok);
        if (ok) begin
            state_in = tbl[1].x; bits_to_rotate = tbl[1].amt; out_ready = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            for (int j = 0; j < 10; j++) begin
                chk($sformatf("hold%0d out_valid", j), 128'(out_valid), 128'h7);
                chk($sformatf("hold%0d in_ready", j), 128'(in_ready), 128'h0);
                for (int i = 0; i < 3; i++)
                    chk($sformatf("hold%0d lpc%0d data", j, lpc[i]), state_out[i], tbl[1].exp);
                state_in = ~tbl[1].x; bits_to_rotate = 128'h3_00000003_00000003_00000003;
                in_valid = 1'b1;
                @(posedge clk); #1;
                in_valid = 1'b0;
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            chk("release out_valid", 128'(out_valid), 128'h0);
            chk("release in_ready", 128'(in_ready), 128'h7);
            for (int i = 0; i < 3; i++)
                chk($sformatf("release lpc%0d kept", lpc[i]), state_out[i], tbl[1].exp);
            repeat (6) @(posedge clk);
            #1;
            chk("no stray op after hold", 128'(out_valid | busy), 128'h0);
        end

        // Reset while BUSY aborts with no output.
        wait_ready("abort", ok);
        if (ok) begin
            state_in = tbl[2].x; bits_to_rotate = tbl[2].amt; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("abort busy before rst", 128'(busy), 128'h7);
            rst = 1'b1;
            @(posedge clk); #1;
            chk("abort out_valid", 128'(out_valid), 128'h0);
            chk("abort busy", 128'(busy), 128'h0);
            chk("abort in_ready in rst", 128'(in_ready), 128'h0);
            for (int i = 0; i < 3; i++)
                chk($sformatf("abort lpc%0d state_out", lpc[i]), state_out[i], '0);
            rst = 1'b0;
            #1;
            chk("abort in_ready after rst", 128'(in_ready), 128'h7);
            repeat (6) @(posedge clk);
            #1;
            chk("abort no late output", 128'(out_valid), 128'h0);
        end
        run_op("after abort", tbl[3].x, tbl[3].amt, tbl[3].exp);

        // Round trip: left-rotate model output fed back with the same amounts.
        for (int k = 0; k < 1000; k++) begin
            logic [127:0] orig, amt, lrot;
            for (int i = 0; i < 4; i++) begin
                orig[i*32 +: 32] = $urandom;
                amt[i*32 +: 32]  = $urandom;
                lrot[i*32 +: 32] = rotl(orig[i*32 +: 32], int'(amt[i*32 +: 5]));
            end
            run_op($sformatf("rand%0d", k), lrot, amt, orig);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
